instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_pkg.sv | 14 +
 rtl/instruction_fetch_if.sv | 33 +++
 rtl/instruction_fetch_imem.sv | 30 +++
 rtl/instruction_fetch.sv | 75 +++++++
 tb/tb_instruction_fetch.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_pkg : constants shared by the fetch pipeline stage |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instruction_fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] PC_RESET = 32'd0;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_if : control, load and IF/ID signals of fetch      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface instruction_fetch_if #(
  parameter int B = 32,
  parameter int N = 8
);

  logic         stall;
  logic         flush;
  logic         PCSrc;
  logic [B-1:0] branch_target;
  logic         load_en;
  logic [N-1:0] load_addr;
  logic [B-1:0] load_data;
  logic [B-1:0] instruction;
  logic [B-1:0] pc_incrementado;
  logic         valid;

  modport master (
    output stall, flush, PCSrc, branch_target, load_en, load_addr, load_data,
    input  instruction, pc_incrementado, valid
  );

  modport slave (
    input  stall, flush, PCSrc, branch_target, load_en, load_addr, load_data,
    output instruction, pc_incrementado, valid
  );

endinterface : instruction_fetch_if
`default_nettype wire

// File: rtl/instruction_fetch_imem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_memory : 2^N x B words, async read, sync write           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instruction_memory #(
  parameter int B = 32,
  parameter int N = 8
) (
  input  wire logic         clk,
  input  wire logic         wr_en,
  input  wire logic [N-1:0] w_addr,
  input  wire logic [B-1:0] w_data,
  input  wire logic [N-1:0] r_addr,
  output logic      [B-1:0] r_data
);

  logic [B-1:0] r_mem [2**N];

  // Contents are deliberately not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[w_addr] <= w_data;
    end
  end

  assign r_data = r_mem[r_addr];

endmodule : instruction_memory
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch : PC, instruction memory and IF/ID pipeline reg    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int B = 32,
  parameter int N = 8
) (
  input wire logic clk,
  input wire logic reset,
  instruction_fetch_if.slave bus
);

  logic [B-1:0] r_pc;
  logic [B-1:0] r_instruction;
  logic [B-1:0] r_pc_inc;
  logic         r_valid;

  logic [B-1:0] w_pc_plus4;
  logic [B-1:0] w_target;
  logic [B-1:0] w_fetch_word;
  logic [N-1:0] w_fetch_idx;

  assign w_pc_plus4  = r_pc + B'(PC_STEP);
  assign w_target    = bus.branch_target & ~B'(3);
  assign w_fetch_idx = r_pc[N+1:2];

  instruction_memory #(
    .B (B),
    .N (N)
  ) u_imem (
    .clk    (clk),
    .wr_en  (bus.load_en),
    .w_addr (bus.load_addr),
    .w_data (bus.load_data),
    .r_addr (w_fetch_idx),
    .r_data (w_fetch_word)
  );

  // A taken branch overrides stall and flush; flush still lets PC advance unless stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= B'(PC_RESET);
      r_instruction <= B'(NOP);
      r_pc_inc      <= '0;
      r_valid       <= 1'b0;
    end else if (bus.PCSrc) begin
      r_pc          <= w_target;
      r_instruction <= B'(NOP);
      r_pc_inc      <= '0;
      r_valid       <= 1'b0;
    end else if (bus.flush) begin
      r_instruction <= B'(NOP);
      r_pc_inc      <= '0;
      r_valid       <= 1'b0;
      if (!bus.stall) begin
        r_pc <= w_pc_plus4;
      end
    end else if (!bus.stall) begin
      r_pc          <= w_pc_plus4;
      r_instruction <= w_fetch_word;
      r_pc_inc      <= w_pc_plus4;
      r_valid       <= 1'b1;
    end
  end

  assign bus.instruction     = r_instruction;
  assign bus.pc_incrementado = r_pc_inc;
  assign bus.valid           = r_valid;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// Testbench for instruction_fetch: directed test-plan scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_instruction_fetch;

  logic clk;
  logic reset;

  instruction_fetch_if #(.B(32), .N(8)) bus ();

  instruction_fetch #(.B(32), .N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  bit check_en;

  // Behavioural model: program memory plus the architectural fetch state.
  bit [31:0] m_mem [256];
  bit [31:0] m_pc;
  bit [31:0] m_instr;
  bit [31:0] m_pcinc;
  bit        m_valid;

  always @(posedge clk) begin
    bit [31:0] fetched;
    fetched = m_mem[(m_pc / 4) % 256];
    if (reset) begin
      m_pc = 0; m_instr = 0; m_pcinc = 0; m_valid = 0;
    end else if (bus.PCSrc) begin
      m_pc = (bus.branch_target / 4) * 4;
      m_instr = 0; m_pcinc = 0; m_valid = 0;
    end else if (bus.flush) begin
      m_instr = 0; m_pcinc = 0; m_valid = 0;
      if (!bus.stall) m_pc = m_pc + 4;
    end else if (!bus.stall) begin
      m_instr = fetched;
      m_pcinc = m_pc + 4;
      m_valid = 1;
      m_pc    = m_pc + 4;
    end
    if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
  end

  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if (bus.instruction !== m_instr || bus.pc_incrementado !== m_pcinc ||
          bus.valid !== m_valid) begin
        miscompares++;
        $display("FAIL model t=%0t: got instr=%h pcinc=%h v=%b, want instr=%h pcinc=%h v=%b",
                 $time, bus.instruction, bus.pc_incrementado, bus.valid,
                 m_instr, m_pcinc, m_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] instr,
                     input logic [31:0] pcinc, input logic v);
    vectors++;
    if (bus.instruction !== instr || bus.pc_incrementado !== pcinc || bus.valid !== v) begin
      miscompares++;
      $display("FAIL %s: got instr=%h pcinc=%h v=%b, want instr=%h pcinc=%h v=%b",
               name, bus.instruction, bus.pc_incrementado, bus.valid, instr, pcinc, v);
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic fl, input logic ps,
                     input logic [31:0] bt, input logic le, input logic [7:0] la,
                     input logic [31:0] ld);
    @(negedge clk);
    reset = rst; bus.stall = st; bus.flush = fl; bus.PCSrc = ps;
    bus.branch_target = bt; bus.load_en = le; bus.load_addr = la; bus.load_data = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 32'h0, 0, 8'h0, 32'h0);
  endtask

  bit [31:0] w4;

  initial begin
    vectors = 0; miscompares = 0; check_en = 0;
    reset = 1; bus.stall = 0; bus.flush = 0; bus.PCSrc = 0;
    bus.branch_target = 0; bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;

    // Load the whole program while reset is held.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] d;
      case (i)
        0:       d = 32'h11;
        1:       d = 32'h22;
        2:       d = 32'h33;
        255:     d = 32'hAB;
        default: d = $urandom;
      endcase
      if (i == 4) w4 = d;
      cyc(1, 0, 0, 0, 32'h0, 1, 8'(i), d);
      check_en = 1;
    end
    chk("reset_state", 32'h0, 32'h0, 1'b0);

    idle(); chk("seq0", 32'h11, 32'd4, 1'b1);
    idle(); chk("seq1", 32'h22, 32'd8, 1'b1);
    cyc(0, 1, 0, 0, 32'h0, 0, 8'h0, 32'h0); chk("stall1", 32'h22, 32'd8, 1'b1);
    cyc(0, 1, 0, 0, 32'h0, 0, 8'h0, 32'h0); chk("stall2", 32'h22, 32'd8, 1'b1);
    idle(); chk("after_stall", 32'h33, 32'd12, 1'b1);

    cyc(0, 1, 0, 1, 32'h0000000B, 0, 8'h0, 32'h0); chk("branch_bubble", 32'h0, 32'h0, 1'b0);
    idle(); chk("branch_target", 32'h33, 32'h0C, 1'b1);

    idle(); // fetches index 3, PC now 0x10
    cyc(0, 1, 1, 0, 32'h0, 0, 8'h0, 32'h0); chk("flush_stall", 32'h0, 32'h0, 1'b0);
    idle(); chk("flush_pc_held", w4, 32'h14, 1'b1);

    cyc(0, 0, 0, 1, 32'hFFFFFFFC, 0, 8'h0, 32'h0); chk("wrap_bubble", 32'h0, 32'h0, 1'b0);
    idle(); chk("wrap_alias", 32'hAB, 32'h0, 1'b1);
    idle(); chk("wrap_next", 32'h11, 32'd4, 1'b1);

    cyc(0, 0, 0, 0, 32'h0, 1, 8'd1, 32'h5A5A5A5A); chk("load_race_old", 32'h22, 32'd8, 1'b1);
    cyc(0, 0, 0, 1, 32'h4, 0, 8'h0, 32'h0); chk("load_race_bubble", 32'h0, 32'h0, 1'b0);
    idle(); chk("load_race_new", 32'h5A5A5A5A, 32'd8, 1'b1);

    cyc(1, 0, 0, 0, 32'h0, 0, 8'h0, 32'h0); chk("mid_reset", 32'h0, 32'h0, 1'b0);
    idle(); chk("mem_retained", 32'h11, 32'd4, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] bt;
      bt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, bt,
          $urandom_range(0, 3) == 0, 8'($urandom), $urandom);
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
